video_sync_out: RTL and testbench
=================================

Name: video_sync_out

Overview:
- Final stage of the video core chain. Sits directly downstream of the sprite/overlay cores and consumes their src_vld/src_rdy/src_fc/src_rgb pixel stream.
- Buffers pixels in a small FIFO and generates VGA raster timing from its own counters. Drives hsync, vsync and rgb to the DAC/pins, one pixel per pixel_tick.
- Aligns the incoming stream to the raster on start-of-frame. Recovers automatically from underflow or misalignment.

Parameters:
- RGB_SIZE, 12, pixel colour width
- H_DISPLAY, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_DISPLAY, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- FIFO_DEPTH, 16, pixel FIFO entries; power of two, >= 4

Ports:
- clk  input  1  system clock
- rst  input  1  reset; asynchronous, active-high
- pixel_tick  input  1  pixel-rate enable; the raster advances one pixel per cycle with pixel_tick=1
- src_vld  input  1  upstream pixel valid
- src_rdy  output  1  upstream ready
- src_fc  input  vga_fc_t  frame control; only hc and vc are used
- src_rgb  input  RGB_SIZE  upstream pixel colour
- underflow_clr  input  1  clears the sticky underflow flag
- vga_hsync  output  1  horizontal sync, active low
- vga_vsync  output  1  vertical sync, active low
- vga_rgb  output  RGB_SIZE  pixel colour; zero during blanking
- underflow  output  1  sticky underflow/misalignment flag
- aligned  output  1  high while in RUN state

Behaviour:
- Totals: H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK; V_TOTAL likewise. Counter widths are $clog2 of the totals.
- Raster counters:
  - h_cnt 0..H_TOTAL-1 and v_cnt 0..V_TOTAL-1 advance only on pixel_tick.
  - h_cnt wraps to 0; v_cnt increments when h_cnt wraps and itself wraps at V_TOTAL-1.
  - Counters free-run in all states.
- Active region: active = (h_cnt < H_DISPLAY) && (v_cnt < V_DISPLAY).
- Sync windows:
  - hsync low for h_cnt in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC).
  - vsync low for v_cnt in [V_DISPLAY+V_FRONT, V_DISPLAY+V_FRONT+V_SYNC).
- Output registers:
  - vga_hsync, vga_vsync and vga_rgb are registered and update on pixel_tick cycles only.
  - They reflect the counter values present in the tick cycle, so latency is 1 clk after the tick.
  - Reset values: vga_hsync=1, vga_vsync=1, vga_rgb=0, underflow=0, aligned=0, counters=0, FIFO empty, state=ALIGN.
- FIFO:
  - Each entry is {sof, rgb}, with sof = (src_fc.hc==0 && src_fc.vc==0).
  - Push on src_vld & src_rdy. src_rdy = !fifo_full in WAIT_FRAME and RUN; src_rdy = 1 in ALIGN.
  - Pop happens only in RUN, on pixel_tick with active=1.
  - Simultaneous push and pop on a full FIFO is not allowed; src_rdy=0 when full.
  - A flush empties the FIFO in one cycle and takes priority over push and pop in that cycle.
- State machine:
  - ALIGN: the FIFO is flushed on entry. Accepted pixels with sof=0 are discarded. An accepted pixel with sof=1 is pushed and the state moves to WAIT_FRAME in the same cycle.
  - WAIT_FRAME: pixels are pushed normally. Move to RUN on the cycle where pixel_tick=1 and h_cnt==H_TOTAL-1 and v_cnt==V_TOTAL-1, so the next tick is pixel (0,0).
  - RUN: aligned=1.
    - On each active tick: pop and drive the rgb.
    - FIFO empty at a required pop: vga_rgb=0 for that pixel, underflow set, go to ALIGN.
    - Popped entry has sof=1 while (h_cnt,v_cnt)!=(0,0): vga_rgb=0, underflow set, go to ALIGN.
    - Popped sof=0 at (0,0) is also a misalignment and is handled identically.
  - Blanking ticks always drive vga_rgb=0 regardless of state.
- underflow: sticky, set as above. Cleared by underflow_clr; if set and clear occur in the same cycle, set wins.
- Reset asserted mid-frame returns every register to its reset value immediately (asynchronous).
- pixel_tick=0: counters, sync and rgb outputs hold their values; push still proceeds.

Test Plan:
- Small timing (H 8/2/2/2, V 4/1/1/1, FIFO_DEPTH 4), pixel_tick=1 every cycle, no input. Required: hsync low at h_cnt 10..11, vsync low at v_cnt 5, rgb=0 throughout, aligned=0.
- Stream a full frame starting at hc=vc=0 with rgb = hc+16*vc, upstream always valid. Required: aligned rises at raster wrap; the second frame's vga_rgb equals the pixel index pattern one clk after each active tick, with no underflow.
- Start the stream at hc=3,vc=1. Required: pixels are discarded until the next (0,0) pixel arrives, then alignment proceeds and the output matches the pattern from the next raster frame.
- Stall src_vld for 6 cycles mid-line while in RUN. Required: FIFO empties, underflow=1, that pixel outputs 0, state returns to ALIGN, and the next frame re-aligns. Then underflow_clr=1 clears the flag.
- Hold snk side back-pressure: pixel_tick every 4th cycle. Required: src_rdy drops when 4 entries are held, no pixels are lost, and hsync/vsync widths scale in ticks, not clocks.
- Assert rst for 1 cycle mid-line. Required: vga_hsync=1, vga_vsync=1, vga_rgb=0 and aligned=0 immediately; counters restart at 0.

Source files
------------

// File: rtl/video_sync_out.sv
// video_sync_out: pixel FIFO plus VGA raster generator that aligns the incoming stream to start-of-frame
package video_sync_out_pkg;
    typedef struct packed {
        logic [10:0] hc;
        logic [10:0] vc;
    } vga_fc_t;
endpackage

module video_sync_out
    import video_sync_out_pkg::*;
#(
    parameter int RGB_SIZE   = 12,
    parameter int H_DISPLAY  = 640,
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int V_DISPLAY  = 480,
    parameter int V_FRONT    = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pixel_tick,
    input  logic                src_vld,
    output logic                src_rdy,
    input  vga_fc_t             src_fc,
    input  logic [RGB_SIZE-1:0] src_rgb,
    input  logic                underflow_clr,
    output logic                vga_hsync,
    output logic                vga_vsync,
    output logic [RGB_SIZE-1:0] vga_rgb,
    output logic                underflow,
    output logic                aligned
);
    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = RGB_SIZE + 1;
    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(H_DISPLAY);
    localparam logic [HW-1:0] HS_LO  = HW'(H_DISPLAY + H_FRONT);
    localparam logic [HW-1:0] HS_HI  = HW'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(V_DISPLAY);
    localparam logic [VW-1:0] VS_LO  = VW'(V_DISPLAY + V_FRONT);
    localparam logic [VW-1:0] VS_HI  = VW'(V_DISPLAY + V_FRONT + V_SYNC);

    typedef enum logic [1:0] {ALIGN, WAIT_FRAME, RUN} state_t;

    state_t              state_q, state_d;
    logic [HW-1:0]       h_cnt_q, h_cnt_d;
    logic [VW-1:0]       v_cnt_q, v_cnt_d;
    logic [AW:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [EW-1:0]       mem_q [FIFO_DEPTH];
    logic                hsync_q, hsync_d, vsync_q, vsync_d, underflow_q, underflow_d;
    logic [RGB_SIZE-1:0] rgb_q, rgb_d;
    logic                active, wrap, sof_in, empty, full, push, pop, err;
    logic [EW-1:0]       head;

    always_comb begin
        active      = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
        wrap        = pixel_tick && (h_cnt_q == H_LAST) && (v_cnt_q == V_LAST);
        sof_in      = (src_fc.hc == '0) && (src_fc.vc == '0);
        empty       = wr_ptr_q == rd_ptr_q;
        full        = (wr_ptr_q ^ rd_ptr_q) == {1'b1, {AW{1'b0}}};
        head        = mem_q[rd_ptr_q[AW-1:0]];
        src_rdy     = (state_q == ALIGN) || !full;
        pop         = (state_q == RUN) && pixel_tick && active;
        // the head's sof flag must coincide exactly with raster pixel (0,0)
        err         = pop && (empty || (head[RGB_SIZE] != ((h_cnt_q == '0) && (v_cnt_q == '0))));
        push        = src_vld && src_rdy && ((state_q != ALIGN) || sof_in);
        wr_ptr_d    = err ? '0 : wr_ptr_q + {{AW{1'b0}}, push};
        rd_ptr_d    = err ? '0 : rd_ptr_q + {{AW{1'b0}}, pop && !empty};
        state_d     = (state_q == ALIGN && push)     ? WAIT_FRAME :
                      (state_q == WAIT_FRAME && wrap) ? RUN :
                      err                             ? ALIGN : state_q;
        h_cnt_d     = !pixel_tick ? h_cnt_q : (h_cnt_q == H_LAST) ? '0 : h_cnt_q + HW'(1);
        v_cnt_d     = !(pixel_tick && h_cnt_q == H_LAST) ? v_cnt_q :
                      (v_cnt_q == V_LAST) ? '0 : v_cnt_q + VW'(1);
        hsync_d     = pixel_tick ? !((h_cnt_q >= HS_LO) && (h_cnt_q < HS_HI)) : hsync_q;
        vsync_d     = pixel_tick ? !((v_cnt_q >= VS_LO) && (v_cnt_q < VS_HI)) : vsync_q;
        rgb_d       = pixel_tick ? ((pop && !err) ? head[RGB_SIZE-1:0] : '0) : rgb_q;
        underflow_d = err || (underflow_q && !underflow_clr);
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q     <= ALIGN;
            h_cnt_q     <= '0;
            v_cnt_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            hsync_q     <= 1'b1;
            vsync_q     <= 1'b1;
            rgb_q       <= '0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            h_cnt_q     <= h_cnt_d;
            v_cnt_q     <= v_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            hsync_q     <= hsync_d;
            vsync_q     <= vsync_d;
            rgb_q       <= rgb_d;
            underflow_q <= underflow_d;
        end

    always_ff @(posedge clk)
        if (push && !err)
            mem_q[wr_ptr_q[AW-1:0]] <= {sof_in, src_rgb};

    assign vga_hsync = hsync_q;
    assign vga_vsync = vsync_q;
    assign vga_rgb   = rgb_q;
    assign underflow = underflow_q;
    assign aligned   = state_q == RUN;
endmodule

// File: tb/tb_video_sync_out.sv
// tb_video_sync_out: random and directed stimulus against a queue-based raster/FIFO reference model
module tb_video_sync_out;
    import video_sync_out_pkg::*;
    localparam int HD = 8, HF = 2, HS = 2, HB = 2;
    localparam int VD = 4, VF = 1, VS = 1, VB = 1;
    localparam int HT = HD + HF + HS + HB;
    localparam int VT = VD + VF + VS + VB;
    localparam int DEP = 4;
    localparam int M_ALIGN = 0, M_WAIT = 1, M_RUN = 2;

    logic        clk = 1'b0;
    logic        rst, pixel_tick, src_vld, src_rdy, underflow_clr;
    vga_fc_t     src_fc;
    logic [11:0] src_rgb, vga_rgb;
    logic        vga_hsync, vga_vsync, underflow, aligned;

    int          n_cmp = 0, n_bad = 0;
    int          m_mode, mh, mv, sh, sv;
    logic [12:0] q[$];
    logic        m_hs, m_vs, m_uf;
    logic [11:0] m_rgb;
    int          hs_run, vs_run, hs_last, vs_last;
    bit          rdy_low_seen, found;

    always #5 clk = ~clk;

    video_sync_out #(
        .RGB_SIZE(12), .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .FIFO_DEPTH(DEP)
    ) dut (
        .clk(clk), .rst(rst), .pixel_tick(pixel_tick), .src_vld(src_vld), .src_rdy(src_rdy),
        .src_fc(src_fc), .src_rgb(src_rgb), .underflow_clr(underflow_clr),
        .vga_hsync(vga_hsync), .vga_vsync(vga_vsync), .vga_rgb(vga_rgb),
        .underflow(underflow), .aligned(aligned)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = M_ALIGN;
        q.delete();
        mh = 0;
        mv = 0;
        m_hs = 1'b1;
        m_vs = 1'b1;
        m_rgb = '0;
        m_uf = 1'b0;
    endtask

    task automatic step();
        logic sof, acc, err;
        int   nmode;
        if (rst) begin
            model_reset();
            return;
        end
        sof   = (src_fc.hc == 0) && (src_fc.vc == 0);
        acc   = src_vld && (m_mode == M_ALIGN || q.size() < DEP);
        err   = 1'b0;
        nmode = m_mode;
        if (pixel_tick) begin
            m_hs  = !(mh >= HD + HF && mh < HD + HF + HS);
            m_vs  = !(mv >= VD + VF && mv < VD + VF + VS);
            m_rgb = '0;
            if (m_mode == M_RUN && mh < HD && mv < VD) begin
                if (q.size() == 0 || q[0][12] != (mh == 0 && mv == 0)) err = 1'b1;
                else m_rgb = q.pop_front() & 13'hfff;
            end
        end
        if (err) begin
            q.delete();
            nmode = M_ALIGN;
            m_uf  = 1'b1;
        end else begin
            if (m_mode == M_ALIGN) begin
                if (acc && sof) begin
                    q.push_back({1'b1, src_rgb});
                    nmode = M_WAIT;
                end
            end else if (acc) q.push_back({sof, src_rgb});
            if (m_mode == M_WAIT && pixel_tick && mh == HT - 1 && mv == VT - 1) nmode = M_RUN;
            if (underflow_clr) m_uf = 1'b0;
        end
        m_mode = nmode;
        if (acc) begin
            sh = (sh + 1) % HD;
            if (sh == 0) sv = (sv + 1) % VD;
        end
        if (pixel_tick) begin
            mh = (mh + 1) % HT;
            if (mh == 0) mv = (mv + 1) % VT;
        end
    endtask

    task automatic cyc(input bit tk, input bit vld, input bit clr);
        @(negedge clk);
        pixel_tick    = tk;
        src_vld       = vld;
        underflow_clr = clr;
        src_fc.hc     = 11'(sh);
        src_fc.vc     = 11'(sv);
        src_rgb       = 12'(sh + 16 * sv);
        @(posedge clk);
        step();
        #1;
        check("hsync", 32'(vga_hsync), 32'(m_hs));
        check("vsync", 32'(vga_vsync), 32'(m_vs));
        check("rgb", 32'(vga_rgb), 32'(m_rgb));
        check("underflow", 32'(underflow), 32'(m_uf));
        check("aligned", 32'(aligned), 32'(m_mode == M_RUN));
        check("src_rdy", 32'(src_rdy), 32'(m_mode == M_ALIGN || q.size() < DEP));
        if (!src_rdy) rdy_low_seen = 1'b1;
        if (!vga_hsync) hs_run++;
        else if (hs_run > 0) begin hs_last = hs_run; hs_run = 0; end
        if (!vga_vsync) vs_run++;
        else if (vs_run > 0) begin vs_last = vs_run; vs_run = 0; end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_hs"}, 32'(vga_hsync), 32'd1);
        check({tag, "_vs"}, 32'(vga_vsync), 32'd1);
        check({tag, "_rgb"}, 32'(vga_rgb), 32'd0);
        check({tag, "_aligned"}, 32'(aligned), 32'd0);
        check({tag, "_uf"}, 32'(underflow), 32'd0);
    endtask

    initial begin
        pixel_tick = 0; src_vld = 0; underflow_clr = 0; src_fc = '0; src_rgb = '0;
        sh = 0; sv = 0; hs_run = 0; vs_run = 0; hs_last = 0; vs_last = 0;
        rdy_low_seen = 0; found = 0;
        rst = 1'b0;
        #1 rst = 1'b1;
        #1 model_reset();
        check_reset_outputs("por");
        cyc(1, 0, 0);
        rst = 1'b0;

        // idle raster: sync windows only, blank rgb, never aligned
        for (int i = 0; i < 120; i++) cyc(1, 0, 0);

        // full stream from (0,0)
        for (int i = 0; i < 300; i++) cyc(1, 1, 0);
        check("stream_aligned", 32'(aligned), 32'd1);
        check("stream_uf", 32'(underflow), 32'd0);

        // restart with the stream starting mid-frame at (3,1)
        @(negedge clk) rst = 1'b1;
        sh = 3;
        sv = 1;
        cyc(1, 0, 0);
        rst = 1'b0;
        for (int i = 0; i < 300; i++) cyc(1, 1, 0);
        check("midstart_aligned", 32'(aligned), 32'd1);
        check("midstart_uf", 32'(underflow), 32'd0);

        // stall mid-line while running
        found = 0;
        for (int i = 0; i < 400 && !found; i++) begin
            if (m_mode == M_RUN && mh == 2 && mv == 1) found = 1;
            else cyc(1, 1, 0);
        end
        check("stall_found", 32'(found), 32'd1);
        for (int i = 0; i < 6; i++) cyc(1, 0, 0);
        check("stall_uf", 32'(underflow), 32'd1);
        check("stall_aligned", 32'(aligned), 32'd0);
        for (int i = 0; i < 300; i++) cyc(1, 1, 0);
        check("realign", 32'(aligned), 32'd1);
        check("uf_sticky", 32'(underflow), 32'd1);
        cyc(1, 1, 1);
        check("uf_clr", 32'(underflow), 32'd0);

        // slow pixel clock: one tick every fourth cycle
        rdy_low_seen = 0;
        for (int i = 0; i < 1600; i++) cyc(i % 4 == 0, 1, 0);
        check("rdy_drop", 32'(rdy_low_seen), 32'd1);
        check("hs_width_clk", 32'(hs_last), 32'(HS * 4));
        check("vs_width_clk", 32'(vs_last), 32'(VS * HT * 4));
        check("slow_uf", 32'(underflow), 32'd0);
        check("slow_aligned", 32'(aligned), 32'd1);

        // random ticks, gaps and clears
        for (int i = 0; i < 2000; i++)
            cyc(1'($urandom_range(0, 1)), $urandom_range(0, 4) != 0, $urandom_range(0, 30) == 0);

        // asynchronous reset mid-line
        found = 0;
        for (int i = 0; i < 300 && !found; i++) begin
            if (mh == 3 && mv == 1) found = 1;
            else cyc(1, 1, 0);
        end
        check("rst_found", 32'(found), 32'd1);
        @(negedge clk) rst = 1'b1;
        #1 model_reset();
        check_reset_outputs("midrst");
        cyc(1, 0, 0);
        rst = 1'b0;
        for (int i = 0; i < 120; i++) cyc(1, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
